// File: rtl/commit_scoreboard.sv
// commit_scoreboard: in-order completion tracker for a dual-issue pipeline.
// Hands out sids at issue, accepts two out-of-order writeback ports, retires
// up to two completed entries per cycle in program order, and flushes entries
// younger than a redirecting sid.
module commit_scoreboard #(
    parameter int SB_AW    = 3,
    parameter int SB_DEPTH = 2 ** SB_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc0_valid_i,
    input  logic              alloc1_valid_i,
    input  logic [4:0]        alloc0_rd_i,
    input  logic [4:0]        alloc1_rd_i,
    output logic              alloc_ready_o,
    output logic [SB_AW:0]    alloc0_sid_o,
    output logic [SB_AW:0]    alloc1_sid_o,
    input  logic              wb0_valid_i,
    input  logic              wb1_valid_i,
    input  logic [SB_AW:0]    wb0_sid_i,
    input  logic [SB_AW:0]    wb1_sid_i,
    input  logic [63:0]       wb0_value_i,
    input  logic [63:0]       wb1_value_i,
    input  logic              redirect_i,
    input  logic [SB_AW:0]    redirect_sid_i,
    output logic              commit0_valid_o,
    output logic              commit1_valid_o,
    output logic [4:0]        commit0_rd_o,
    output logic [4:0]        commit1_rd_o,
    output logic [63:0]       commit0_value_o,
    output logic [63:0]       commit1_value_o,
    output logic [SB_AW:0]    commit0_sid_o,
    output logic [SB_AW:0]    commit1_sid_o,
    output logic [31:0]       pending_rd_o,
    output logic [SB_AW:0]    count_o
);
    localparam int SW = SB_AW + 1;

    logic [SB_DEPTH-1:0] valid_q, done_q;
    logic [4:0]          rd_q    [SB_DEPTH];
    logic [63:0]         value_q [SB_DEPTH];
    logic [SW-1:0]       head_q, tail_q, count_q;

    logic [SB_AW-1:0] head_idx, head1_idx, tail_idx, tail1_idx;
    logic [SW-1:0]    redir_off, wb0_off, wb1_off;
    logic             redir_ok, wb0_ok, wb1_ok;
    logic             commit0_ok, commit1_ok, alloc0_fire, alloc1_fire;
    logic [SW-1:0]    n_alloc, n_commit, n_flush;
    logic [SW:0]      count_d;

    logic [SB_DEPTH-1:0]       flush_vec, alloc_vec, clear_vec, wb0_hit, wb1_hit;
    logic [SB_DEPTH-1:0][31:0] pend_vec;

    assign head_idx  = head_q[SB_AW-1:0];
    assign head1_idx = head_idx + 1'b1;
    assign tail_idx  = tail_q[SB_AW-1:0];
    assign tail1_idx = tail_idx + 1'b1;

    assign alloc_ready_o = (count_q <= SW'(SB_DEPTH - 2));
    assign alloc0_sid_o  = tail_q;
    assign alloc1_sid_o  = tail_q + SW'(1);
    assign count_o       = count_q;

    // Age offsets relative to head; an offset below count means the sid is in [head, tail).
    assign redir_off = redirect_sid_i - head_q;
    assign wb0_off   = wb0_sid_i - head_q;
    assign wb1_off   = wb1_sid_i - head_q;
    assign redir_ok  = redirect_i && (redir_off < count_q);

    // Writebacks aimed at entries being flushed this cycle are dropped.
    assign wb0_ok = wb0_valid_i && (wb0_off < count_q) && valid_q[wb0_sid_i[SB_AW-1:0]]
                    && !(redir_ok && (wb0_off > redir_off));
    assign wb1_ok = wb1_valid_i && (wb1_off < count_q) && valid_q[wb1_sid_i[SB_AW-1:0]]
                    && !(redir_ok && (wb1_off > redir_off));

    // Retire from pre-edge state; head+1 cannot retire if it is being flushed.
    assign commit0_ok = valid_q[head_idx] & done_q[head_idx];
    assign commit1_ok = commit0_ok & valid_q[head1_idx] & done_q[head1_idx]
                        & ~(redir_ok && (redir_off == '0));

    assign alloc0_fire = alloc_ready_o & alloc0_valid_i & ~redir_ok;
    assign alloc1_fire = alloc0_fire & alloc1_valid_i;

    assign n_alloc  = SW'(alloc0_fire) + SW'(alloc1_fire);
    assign n_commit = SW'(commit0_ok) + SW'(commit1_ok);
    assign n_flush  = redir_ok ? (count_q - redir_off - SW'(1)) : '0;
    assign count_d  = {1'b0, count_q} + {1'b0, n_alloc} - {1'b0, n_commit} - {1'b0, n_flush};

    generate
        for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_entry
            localparam logic [SB_AW-1:0] IDX = SB_AW'(gi);
            logic [SB_AW-1:0] off;
            assign off           = IDX - head_idx;
            assign flush_vec[gi] = redir_ok && ({1'b0, off} > redir_off);
            assign alloc_vec[gi] = (alloc0_fire && (tail_idx == IDX)) ||
                                   (alloc1_fire && (tail1_idx == IDX));
            assign clear_vec[gi] = (commit0_ok && (head_idx == IDX)) ||
                                   (commit1_ok && (head1_idx == IDX));
            assign wb0_hit[gi]   = wb0_ok && (wb0_sid_i[SB_AW-1:0] == IDX);
            assign wb1_hit[gi]   = wb1_ok && (wb1_sid_i[SB_AW-1:0] == IDX);
            assign pend_vec[gi]  = valid_q[gi] ? (32'd1 << rd_q[gi]) : 32'd0;
        end
    endgenerate

    // Destination-register summary of all live entries; r0 never counts.
    always_comb begin
        logic [31:0] pend;
        pend = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            pend = pend | pend_vec[i];
        end
        pending_rd_o = {pend[31:1], 1'b0};
    end

    // Entry status bits and pointers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                if (alloc_vec[i]) begin
                    valid_q[i] <= 1'b1;
                    done_q[i]  <= 1'b0;
                end else if (flush_vec[i] || clear_vec[i]) begin
                    valid_q[i] <= 1'b0;
                    done_q[i]  <= 1'b0;
                end else if (wb0_hit[i] || wb1_hit[i]) begin
                    done_q[i]  <= 1'b1;
                end
            end
            head_q  <= head_q + n_commit;
            tail_q  <= redir_ok ? (redirect_sid_i + SW'(1)) : (tail_q + n_alloc);
            count_q <= count_d[SW-1:0];
        end
    end

    // Entry payload: rd at allocation, value at writeback (wb1 wins a tie).
    always_ff @(posedge clk) begin
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (alloc1_fire && (tail1_idx == SB_AW'(i))) begin
                rd_q[i] <= alloc1_rd_i;
            end else if (alloc_vec[i]) begin
                rd_q[i] <= alloc0_rd_i;
            end
            if (wb1_hit[i]) begin
                value_q[i] <= wb1_value_i;
            end else if (wb0_hit[i]) begin
                value_q[i] <= wb0_value_i;
            end
        end
    end

    // Registered retire ports; data holds when nothing retires.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            commit0_valid_o <= 1'b0;
            commit1_valid_o <= 1'b0;
            commit0_rd_o    <= '0;
            commit1_rd_o    <= '0;
            commit0_value_o <= '0;
            commit1_value_o <= '0;
            commit0_sid_o   <= '0;
            commit1_sid_o   <= '0;
        end else begin
            commit0_valid_o <= commit0_ok;
            commit1_valid_o <= commit1_ok;
            if (commit0_ok) begin
                commit0_rd_o    <= rd_q[head_idx];
                commit0_value_o <= value_q[head_idx];
                commit0_sid_o   <= head_q;
            end
            if (commit1_ok) begin
                commit1_rd_o    <= rd_q[head1_idx];
                commit1_value_o <= value_q[head1_idx];
                commit1_sid_o   <= head_q + SW'(1);
            end
        end
    end

    // Occupancy can never exceed the depth (nor wrap below zero).
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (count_d <= (SW + 1)'(SB_DEPTH));
        end
    end
endmodule

// File: tb/tb_commit_scoreboard.sv
// Scoreboard bench for commit_scoreboard: the driver runs a queue-based
// program-order model and pushes expected retirements; a monitor pops them
// whenever the DUT raises a commit strobe.
module tb_commit_scoreboard;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        alloc0_valid_i, alloc1_valid_i;
    logic [4:0]  alloc0_rd_i, alloc1_rd_i;
    logic        alloc_ready_o;
    logic [3:0]  alloc0_sid_o, alloc1_sid_o;
    logic        wb0_valid_i, wb1_valid_i;
    logic [3:0]  wb0_sid_i, wb1_sid_i;
    logic [63:0] wb0_value_i, wb1_value_i;
    logic        redirect_i;
    logic [3:0]  redirect_sid_i;
    logic        commit0_valid_o, commit1_valid_o;
    logic [4:0]  commit0_rd_o, commit1_rd_o;
    logic [63:0] commit0_value_o, commit1_value_o;
    logic [3:0]  commit0_sid_o, commit1_sid_o;
    logic [31:0] pending_rd_o;
    logic [3:0]  count_o;

    commit_scoreboard dut (
        .clk(clk), .rst_n(rst_n),
        .alloc0_valid_i(alloc0_valid_i), .alloc1_valid_i(alloc1_valid_i),
        .alloc0_rd_i(alloc0_rd_i), .alloc1_rd_i(alloc1_rd_i),
        .alloc_ready_o(alloc_ready_o),
        .alloc0_sid_o(alloc0_sid_o), .alloc1_sid_o(alloc1_sid_o),
        .wb0_valid_i(wb0_valid_i), .wb1_valid_i(wb1_valid_i),
        .wb0_sid_i(wb0_sid_i), .wb1_sid_i(wb1_sid_i),
        .wb0_value_i(wb0_value_i), .wb1_value_i(wb1_value_i),
        .redirect_i(redirect_i), .redirect_sid_i(redirect_sid_i),
        .commit0_valid_o(commit0_valid_o), .commit1_valid_o(commit1_valid_o),
        .commit0_rd_o(commit0_rd_o), .commit1_rd_o(commit1_rd_o),
        .commit0_value_o(commit0_value_o), .commit1_value_o(commit1_value_o),
        .commit0_sid_o(commit0_sid_o), .commit1_sid_o(commit1_sid_o),
        .pending_rd_o(pending_rd_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  sid;
        logic [4:0]  rd;
        bit          done;
        logic [63:0] value;
    } ent_t;

    typedef struct {
        bit          slot;
        logic [3:0]  sid;
        logic [4:0]  rd;
        logic [63:0] value;
    } cm_t;

    ent_t mq[$];          // live entries, oldest first
    cm_t  exp_q[$];       // expected retirements for the coming edge
    logic [3:0] m_head = 4'd0;
    cm_t  h0, h1;         // last retired values per port

    int n_cmp = 0;
    int n_fail = 0;

    // stimulus for the next edge
    bit          s_rst_n, s_a0, s_a1, s_w0, s_w1, s_redir;
    logic [4:0]  s_rd0, s_rd1;
    logic [3:0]  s_w0sid, s_w1sid, s_rsid;
    logic [63:0] s_w0val, s_w1val;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] p;
        p = '0;
        foreach (mq[i]) if (mq[i].rd != 5'd0) p[mq[i].rd] = 1'b1;
        return p;
    endfunction

    task automatic clr();
        s_rst_n = 1'b1; s_a0 = 0; s_a1 = 0; s_w0 = 0; s_w1 = 0; s_redir = 0;
        s_rd0 = '0; s_rd1 = '0; s_w0sid = '0; s_w1sid = '0; s_rsid = '0;
        s_w0val = '0; s_w1val = '0;
    endtask

    // Advance the reference model across one edge with the current stimulus.
    task automatic model_step();
        int n, nc, roff, off;
        bit rok;
        logic [3:0] tail, tail1;
        cm_t c;
        if (!s_rst_n) begin
            mq.delete();
            m_head = 4'd0;
            h0 = '{slot: 0, sid: 0, rd: 0, value: 0};
            h1 = '{slot: 1, sid: 0, rd: 0, value: 0};
            return;
        end
        n     = mq.size();
        tail  = m_head + 4'(n);
        tail1 = tail + 4'd1;
        roff  = int'(4'(s_rsid - m_head));
        rok   = s_redir && (roff < n);
        nc    = 0;
        if (n > 0 && mq[0].done) begin
            c = '{slot: 0, sid: mq[0].sid, rd: mq[0].rd, value: mq[0].value};
            exp_q.push_back(c); h0 = c; nc = 1;
            if (n > 1 && mq[1].done && !(rok && roff == 0)) begin
                c = '{slot: 1, sid: mq[1].sid, rd: mq[1].rd, value: mq[1].value};
                exp_q.push_back(c); h1 = c; nc = 2;
            end
        end
        if (n <= 6 && s_a0 && !rok) begin
            chk("alloc0_sid", alloc0_sid_o, tail);
            if (s_a1) chk("alloc1_sid", alloc1_sid_o, tail1);
        end
        if (s_w0) begin
            off = int'(4'(s_w0sid - m_head));
            if (off < n && !(rok && off > roff)) begin mq[off].done = 1; mq[off].value = s_w0val; end
        end
        if (s_w1) begin
            off = int'(4'(s_w1sid - m_head));
            if (off < n && !(rok && off > roff)) begin mq[off].done = 1; mq[off].value = s_w1val; end
        end
        if (rok) while (mq.size() > roff + 1) void'(mq.pop_back());
        repeat (nc) begin void'(mq.pop_front()); m_head = m_head + 4'd1; end
        if (n <= 6 && s_a0 && !rok) begin
            mq.push_back('{sid: tail, rd: s_rd0, done: 0, value: 0});
            if (s_a1) mq.push_back('{sid: tail1, rd: s_rd1, done: 0, value: 0});
        end
    endtask

    // Drive one cycle (called at a falling edge), then wait for the next one.
    task automatic tick();
        rst_n = s_rst_n;
        alloc0_valid_i = s_a0; alloc1_valid_i = s_a1;
        alloc0_rd_i = s_rd0;   alloc1_rd_i = s_rd1;
        wb0_valid_i = s_w0; wb0_sid_i = s_w0sid; wb0_value_i = s_w0val;
        wb1_valid_i = s_w1; wb1_sid_i = s_w1sid; wb1_value_i = s_w1val;
        redirect_i = s_redir; redirect_sid_i = s_rsid;
        #1;
        model_step();
        @(negedge clk);
    endtask

    function automatic logic [3:0] pick_sid();
        if (mq.size() > 0 && $urandom_range(0, 4) != 0)
            return mq[$urandom_range(0, mq.size() - 1)].sid;
        return 4'($urandom);
    endfunction

    // Monitor: one line per retirement, checked against the expected queue.
    initial begin
        cm_t c;
        forever begin
            @(posedge clk);
            #1;
            if (commit0_valid_o) begin
                chk("commit0_expected", (exp_q.size() != 0 && exp_q[0].slot == 0), 1);
                if (exp_q.size() != 0 && exp_q[0].slot == 0) begin
                    c = exp_q.pop_front();
                    $display("commit0 sid=%0d rd=%0d value=%0h", commit0_sid_o, commit0_rd_o, commit0_value_o);
                    chk("commit0_sid", commit0_sid_o, c.sid);
                    chk("commit0_rd", commit0_rd_o, c.rd);
                    chk("commit0_value", commit0_value_o, c.value);
                end
            end else begin
                chk("commit0_hold_sid", commit0_sid_o, h0.sid);
                chk("commit0_hold_value", commit0_value_o, h0.value);
            end
            if (commit1_valid_o) begin
                chk("commit1_expected", (exp_q.size() != 0 && exp_q[0].slot == 1), 1);
                if (exp_q.size() != 0 && exp_q[0].slot == 1) begin
                    c = exp_q.pop_front();
                    $display("commit1 sid=%0d rd=%0d value=%0h", commit1_sid_o, commit1_rd_o, commit1_value_o);
                    chk("commit1_sid", commit1_sid_o, c.sid);
                    chk("commit1_rd", commit1_rd_o, c.rd);
                    chk("commit1_value", commit1_value_o, c.value);
                end
            end else begin
                chk("commit1_hold_sid", commit1_sid_o, h1.sid);
                chk("commit1_hold_rd", commit1_rd_o, h1.rd);
            end
            chk("commit_missing", exp_q.size(), 0);
            exp_q.delete();
            chk("count_o", count_o, mq.size());
            chk("alloc_ready_o", alloc_ready_o, (mq.size() <= 6));
            chk("pending_rd_o", pending_rd_o, model_pending());
        end
    end

    initial begin
        logic [3:0] base;
        int wb_pct;
        clr(); s_rst_n = 0;
        tick(); tick();
        // writeback to an unallocated sid with an empty buffer
        clr(); s_w0 = 1; s_w0sid = 4'd7; s_w0val = 64'h77; tick();
        clr(); tick();
        // pair allocation, out-of-order writeback, paired retire; same rd twice
        clr(); s_a0 = 1; s_a1 = 1; s_rd0 = 5; s_rd1 = 5; tick();
        clr(); s_w1 = 1; s_w1sid = 4'd1; s_w1val = 64'hB; tick();
        clr(); s_w0 = 1; s_w0sid = 4'd0; s_w0val = 64'hA; tick();
        clr(); s_a0 = 1; s_rd0 = 0; tick();
        clr(); tick(); tick();
        // fill to full, then drain two
        clr(); s_rst_n = 0; tick();
        for (int k = 0; k < 5; k++) begin
            clr(); s_a0 = 1; s_a1 = 1; s_rd0 = 5'(k + 1); s_rd1 = 5'(k + 9); tick();
        end
        clr(); s_w0 = 1; s_w0sid = 4'd0; s_w0val = 64'h10; s_w1 = 1; s_w1sid = 4'd1; s_w1val = 64'h11; tick();
        clr(); tick();
        clr(); s_a0 = 1; s_a1 = 1; tick();
        clr(); tick();
        // redirect while a younger writeback lands
        clr(); s_rst_n = 0; tick();
        base = m_head;
        for (int k = 0; k < 3; k++) begin
            clr(); s_a0 = 1; s_a1 = 1; s_rd0 = 5'(2 * k + 1); s_rd1 = 5'(2 * k + 2); tick();
        end
        clr(); s_w0 = 1; s_w0sid = base;        s_w0val = 64'h100; s_w1 = 1; s_w1sid = base + 4'd1; s_w1val = 64'h101; tick();
        clr(); s_w0 = 1; s_w0sid = base + 4'd2; s_w0val = 64'h102; s_w1 = 1; s_w1sid = base + 4'd3; s_w1val = 64'h103; tick();
        clr(); s_w0 = 1; s_w0sid = base + 4'd5; s_w0val = 64'h105; s_w1 = 1; s_w1sid = base + 4'd4; s_w1val = 64'h104;
        s_redir = 1; s_rsid = base + 4'd2; tick();
        clr(); s_a0 = 1; s_rd0 = 3; tick();
        clr(); tick(); tick();
        // randomized traffic with occasional redirects and resets
        for (int i = 0; i < 3000; i++) begin
            wb_pct = (i < 1500) ? 35 : 75;
            clr();
            s_rst_n = ($urandom_range(0, 299) != 0);
            s_a0    = ($urandom_range(0, 3) != 0);
            s_a1    = $urandom_range(0, 1) != 0;
            s_rd0   = 5'($urandom_range(0, 11));
            s_rd1   = 5'($urandom_range(0, 31));
            s_w0    = ($urandom_range(0, 99) < wb_pct);
            s_w0sid = pick_sid();
            s_w0val = {$urandom, $urandom};
            s_w1    = ($urandom_range(0, 99) < wb_pct);
            s_w1sid = ($urandom_range(0, 7) == 0) ? s_w0sid : pick_sid();
            s_w1val = {$urandom, $urandom};
            s_redir = ($urandom_range(0, 19) == 0);
            s_rsid  = pick_sid();
            tick();
        end
        clr(); tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/commit_scoreboard.md
# commit_scoreboard

In-order completion tracker for the dual-issue pipeline. It hands out scoreboard IDs (sid) at issue and accepts both writeback ports out of order by sid. It retires up to two completed instructions per cycle, in program order, to the register-file write ports. It also applies writeback redirects by discarding every entry younger than the redirecting sid.

## Interface
- SB_AW, 3, log2 of entry count; sid is SB_AW+1 bits (MSB = wrap bit)
- SB_DEPTH, 2**SB_AW, number of entries (8)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- alloc0_valid_i / alloc1_valid_i  in  1  issue slot requests an entry; slot1 is younger than slot0
- alloc0_rd_i / alloc1_rd_i  in  5  destination register (0 = no register write)
- alloc_ready_o  out  1  at least 2 entries free (registered count)
- alloc0_sid_o / alloc1_sid_o  out  SB_AW+1  sid granted to slot0 / slot1 this cycle (combinational: tail, tail+1)
- wb0_valid_i / wb1_valid_i  in  1  writeback result present
- wb0_sid_i / wb1_sid_i  in  SB_AW+1  sid being completed
- wb0_value_i / wb1_value_i  in  64  result value
- redirect_i  in  1  discard entries younger than redirect_sid_i
- redirect_sid_i  in  SB_AW+1  sid of the redirecting instruction (kept)
- commit0_valid_o / commit1_valid_o  out  1  registered retire strobe; commit1 is the younger instruction
- commit0_rd_o / commit1_rd_o  out  5  retiring destination
- commit0_value_o / commit1_value_o  out  64  retiring value
- commit0_sid_o / commit1_sid_o  out  SB_AW+1  retiring sid
- pending_rd_o  out  32  bit r set while an allocated, uncommitted entry targets rd r (bit 0 always 0)
- count_o  out  SB_AW+1  occupied entries

## Operation
- The entry store is a circular buffer. Each entry holds valid, done, rd, and value[63:0].
- head and tail are SB_AW+1-bit pointers with wrap bit. Index is the low SB_AW bits. Empty: head==tail. Full: count==SB_DEPTH.
- Allocation:
  - Happens only when alloc_ready_o=1.
  - alloc1 is honoured only together with alloc0; alloc1 without alloc0 is ignored.
  - An allocated entry gets valid=1, done=0.
  - tail advances by the number of slots allocated.
- Writeback:
  - Sets done=1 and stores the value in the entry index given by the sid.
  - A writeback is ignored if the entry is invalid, or if its sid is not in [head, tail) under wrap-aware compare.
  - wb0 and wb1 to the same sid in one cycle: wb1 wins.
- Commit:
  - Each edge, if head is valid&done, load commit0_* from it.
  - Load commit1_* from head+1 as well if that entry is valid&done too.
  - Committed entries are cleared and head advances by 0, 1 or 2.
  - Commit uses entry state from before the same edge's writeback update.
  - With no commit, commit*_valid_o=0 and the other commit outputs hold their last value.
- Redirect:
  - Applies when redirect_i=1 and redirect_sid_i is in [head, tail).
  - Entries strictly younger than redirect_sid_i are invalidated and tail <= redirect_sid_i+1.
  - Allocation in the same cycle is suppressed, and alloc*_sid_o values that cycle are void.
  - Writebacks targeting flushed entries in the same cycle are dropped.
  - Commit in the same cycle proceeds normally.
  - An out-of-range redirect_sid_i is ignored entirely.
- count_next = count + allocated − committed − flushed. It saturates at neither end: overflow is impossible by construction and is an assertion target.
- pending_rd_o is combinational over valid entries with rd!=0.

## Timing
- Reset (rst_n=0 at an edge):
  - head=tail=0, all valid/done=0, count_o=0.
  - commit*_valid_o=0 and all commit data outputs=0.
  - alloc_ready_o=1, pending_rd_o=0.
  - rst_n=0 mid-operation discards all in-flight entries with no commit.
- Allocate-to-writeback: a writeback may be sampled at the edge after the allocating edge.
- Writeback-to-commit: wb sampled at edge k sets done. commit*_valid_o is high during the cycle after edge k+1, provided all older entries are committed.
- alloc_ready_o reflects count at the last edge only; a same-cycle commit does not free space.
- Wrap: the sid sequence ...,6,7,8(wrap bit 1, index 0),... Age compare uses (sid − head) mod 2^(SB_AW+1).

## Test plan
- Reset then alloc both slots → sids 0,1. wb1 sid1=0xB first, wb0 sid0=0xA next cycle → commit0 sid0 0xA and commit1 sid1 0xB in the same cycle, count_o 2→0.
- Allocate 8 entries → alloc_ready_o drops at count 7 and 8. Commit 2 → alloc_ready_o=1 one cycle later, and the next sids are 8,9 (wrap bit set, index 0,1).
- Allocate sids 0–5, writeback all, redirect_sid_i=2 in the same cycle as wb for sid4 → commits sid0,1,2 only, next alloc sid is 3, sid4 value never retired.
- Allocate rd=5 for sid0 and rd=5 for sid1 → pending_rd_o[5]=1 until sid1 commits. rd=0 alloc → pending_rd_o[0] stays 0.
- wb to an unallocated sid 7 with head=tail=0 → no state change, no commit.
- Assert rst_n=0 with 4 entries done but not committed → next cycle count_o=0, commit*_valid_o=0, alloc_ready_o=1.
